// File: rtl/vec_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vec_pkg
// Description : Shared definitions for the vector execution controller.
//               Holds the opcode encodings, the controller state enum and
//               the default vector/lane widths.
// Revision    : 1.0 - initial release
// ============================================================================
package vec_pkg;

    localparam int VLEN_DEF   = 512;
    localparam int ELEM_W_DEF = 32;

    localparam logic [2:0] OP_ADD   = 3'b000;
    localparam logic [2:0] OP_MUL   = 3'b001;
    localparam logic [2:0] OP_STORE = 3'b010;
    localparam logic [2:0] OP_LOAD  = 3'b011;
    localparam logic [2:0] OP_NOP   = 3'b100;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_MEM  = 2'd2,
        S_WB   = 2'd3
    } state_t;

endpackage : vec_pkg
`default_nettype wire

// File: rtl/vec_lane_alu.sv
`default_nettype none
// ============================================================================
// Module      : vec_lane_alu
// Description : Combinational lane-wise unsigned add / multiply.
//               ADD : lo = lane sum mod 2^ELEM_W, hi = carry-out (zero-ext).
//               MUL : lo/hi = lower/upper halves of the 2*ELEM_W product.
// Ports       : op   - opcode (only OP_MUL selects the product)
//               a, b - packed operand vectors (LANES x ELEM_W)
//               lo   - low result vector
//               hi   - high result vector
// Revision    : 1.0 - initial release
// ============================================================================
module vec_lane_alu
    import vec_pkg::*;
#(
    parameter int ELEM_W = ELEM_W_DEF,
    parameter int LANES  = VLEN_DEF / ELEM_W_DEF
) (
    input  logic [2:0]              op,
    input  logic [ELEM_W*LANES-1:0] a,
    input  logic [ELEM_W*LANES-1:0] b,
    output logic [ELEM_W*LANES-1:0] lo,
    output logic [ELEM_W*LANES-1:0] hi
);

    logic w_is_mul;
    assign w_is_mul = (op == OP_MUL);

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic [ELEM_W:0]     w_sum;
        logic [2*ELEM_W-1:0] w_prod;

        assign w_sum  = {1'b0, a[i*ELEM_W +: ELEM_W]} + {1'b0, b[i*ELEM_W +: ELEM_W]};
        assign w_prod = {{ELEM_W{1'b0}}, a[i*ELEM_W +: ELEM_W]} *
                        {{ELEM_W{1'b0}}, b[i*ELEM_W +: ELEM_W]};

        assign lo[i*ELEM_W +: ELEM_W] = w_is_mul ? w_prod[ELEM_W-1:0] : w_sum[ELEM_W-1:0];
        assign hi[i*ELEM_W +: ELEM_W] = w_is_mul ? w_prod[2*ELEM_W-1:ELEM_W]
                                                 : {{(ELEM_W-1){1'b0}}, w_sum[ELEM_W]};
    end

endmodule : vec_lane_alu
`default_nettype wire

// File: rtl/vec_exec_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : vec_exec_ctrl
// Description : Vector execution controller. Owns the vector register file
//               and runs one instruction at a time through IDLE/EXEC/MEM/WB.
// Ports       : clk, rst              - clock, async active-high reset
//               instr_*               - instruction valid/ready handshake
//               ext_wr_*              - host register write (IDLE only)
//               dbg_rd_addr/_data     - combinational register peek
//               mem_*                 - external memory req/ack interface
//               low_result/high_result- last arithmetic results
//               busy, done, err       - status / retire / illegal-op pulses
// Revision    : 1.0 - initial release
// ============================================================================
module vec_exec_ctrl
    import vec_pkg::*;
#(
    parameter int VLEN     = VLEN_DEF,
    parameter int ELEM_W   = ELEM_W_DEF,
    parameter int NUM_REGS = 4,
    parameter int MEM_AW   = 9,
    parameter int MUL_LAT  = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        instr_valid,
    output logic                        instr_ready,
    input  logic [2:0]                  instr_op,
    input  logic [$clog2(NUM_REGS)-1:0] instr_rd,
    input  logic [$clog2(NUM_REGS)-1:0] instr_rs1,
    input  logic [$clog2(NUM_REGS)-1:0] instr_rs2,
    input  logic [MEM_AW-1:0]           instr_maddr,
    input  logic                        ext_wr_en,
    input  logic [$clog2(NUM_REGS)-1:0] ext_wr_addr,
    input  logic [VLEN-1:0]             ext_wr_data,
    input  logic [$clog2(NUM_REGS)-1:0] dbg_rd_addr,
    output logic [VLEN-1:0]             dbg_rd_data,
    output logic                        mem_req,
    output logic                        mem_we,
    output logic [MEM_AW-1:0]           mem_addr,
    output logic [VLEN-1:0]             mem_wdata,
    input  logic                        mem_ack,
    input  logic [VLEN-1:0]             mem_rdata,
    output logic [VLEN-1:0]             low_result,
    output logic [VLEN-1:0]             high_result,
    output logic                        busy,
    output logic                        done,
    output logic                        err
);

    localparam int RW    = $clog2(NUM_REGS);
    localparam int LANES = VLEN / ELEM_W;
    // Down-counter only needs to reach MUL_LAT-1.
    localparam int CW    = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

    state_t          r_state;
    logic [VLEN-1:0] r_regs [NUM_REGS];
    logic [2:0]      r_op;
    logic [RW-1:0]   r_rd;
    logic [VLEN-1:0] r_a;
    logic [VLEN-1:0] r_b;
    logic [VLEN-1:0] r_ldata;
    logic [CW-1:0]   r_cnt;

    logic [VLEN-1:0] w_lo;
    logic [VLEN-1:0] w_hi;
    logic [RW-1:0]   w_rd_hi;
    logic            w_legal;

    vec_lane_alu #(
        .ELEM_W (ELEM_W),
        .LANES  (LANES)
    ) u_alu (
        .op (r_op),
        .a  (r_a),
        .b  (r_b),
        .lo (w_lo),
        .hi (w_hi)
    );

    assign instr_ready = (r_state == S_IDLE);
    assign busy        = (r_state != S_IDLE);
    assign dbg_rd_data = r_regs[dbg_rd_addr];
    // Power-of-two register count makes the high-half destination wrap for free.
    assign w_rd_hi     = r_rd + RW'(1);
    assign w_legal     = (instr_op <= OP_NOP);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_op        <= OP_ADD;
            r_rd        <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_ldata     <= '0;
            r_cnt       <= '0;
            low_result  <= '0;
            high_result <= '0;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            done        <= 1'b0;
            err         <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    // Operand reads below see the pre-write contents when a
                    // host write lands on the same edge as an accept.
                    if (ext_wr_en) begin
                        r_regs[ext_wr_addr] <= ext_wr_data;
                    end
                    if (instr_valid) begin
                        if (w_legal) begin
                            r_op <= instr_op;
                            r_rd <= instr_rd;
                            r_a  <= r_regs[instr_rs1];
                            r_b  <= r_regs[instr_rs2];
                        end
                        case (instr_op)
                            OP_ADD: begin
                                r_cnt   <= '0;
                                r_state <= S_EXEC;
                            end
                            OP_MUL: begin
                                r_cnt   <= CW'(MUL_LAT - 1);
                                r_state <= S_EXEC;
                            end
                            OP_STORE, OP_LOAD: begin
                                mem_req   <= 1'b1;
                                mem_we    <= (instr_op == OP_STORE);
                                mem_addr  <= instr_maddr;
                                mem_wdata <= r_regs[instr_rd];
                                r_state   <= S_MEM;
                            end
                            OP_NOP: begin
                                r_state <= S_WB;
                            end
                            default: begin
                                err <= 1'b1;
                            end
                        endcase
                    end
                end
                S_EXEC: begin
                    if (r_cnt == '0) begin
                        low_result  <= w_lo;
                        high_result <= w_hi;
                        r_state     <= S_WB;
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                S_MEM: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        if (r_op == OP_LOAD) begin
                            r_ldata <= mem_rdata;
                        end
                        r_state <= S_WB;
                    end
                end
                S_WB: begin
                    if ((r_op == OP_ADD) || (r_op == OP_MUL)) begin
                        r_regs[r_rd]    <= low_result;
                        r_regs[w_rd_hi] <= high_result;
                    end else if (r_op == OP_LOAD) begin
                        r_regs[r_rd] <= r_ldata;
                    end
                    done    <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule : vec_exec_ctrl
`default_nettype wire
